// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - receive byte FIFO with engine capture handshake and sticky error flags
module rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_rdy,
  input  logic          rx_ferr,
  input  logic          rx_perr,
  input  logic          rx_ovf,
  output logic          rx_clr,
  input  logic          rd,
  input  logic          err_clr,
  output logic [7:0]    dout,
  output logic          head_ferr,
  output logic          head_perr,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          drop,
  output logic          ovf
);

  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [9:0]    mem [DEPTH];
  logic          cap;
  logic          pop;
  logic          wr_ok;

  // A capture is attempted only from IDLE; a full FIFO still accepts it if a pop frees a slot on the same edge.
  always_comb begin
    cap   = (state == ST_IDLE) && rx_rdy;
    pop   = rd && !empty;
    wr_ok = cap && ((count != DEPTH_CNT) || pop);
  end

  // Capture FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture FSM next state: one byte per rx_rdy assertion, re-armed only once rx_rdy drops.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rx_rdy) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_WAIT;
      ST_WAIT: if (!rx_rdy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture FSM outputs: the clear pulse is decoded purely from the state register.
  always_comb begin
    rx_clr = (state == ST_ACK);
  end

  // Entry storage is intentionally unreset; it is masked by empty on the outputs.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {rx_perr, rx_ferr, rx_data};
    end
  end

  // Pointers and occupancy; a simultaneous write and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a set condition wins over a simultaneous host clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (cap && !wr_ok) drop <= 1'b1;
      else if (err_clr)  drop <= 1'b0;
      if (rx_ovf)        ovf  <= 1'b1;
      else if (err_clr)  ovf  <= 1'b0;
    end
  end

  // Status and fall-through head view, zeroed when empty.
  always_comb begin
    empty     = (count == '0);
    full      = (count == DEPTH_CNT);
    dout      = 8'h00;
    head_ferr = 1'b0;
    head_perr = 1'b0;
    if (!empty) begin
      dout      = mem[rd_ptr][7:0];
      head_ferr = mem[rd_ptr][8];
      head_perr = mem[rd_ptr][9];
    end
  end

endmodule

// File: tb/tb_rx_fifo.sv
// tb/tb_rx_fifo.sv - self-checking bench for rx_fifo
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy = 1'b0;
  logic       rx_ferr = 1'b0;
  logic       rx_perr = 1'b0;
  logic       rx_ovf = 1'b0;
  logic       rx_clr;
  logic       rd = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dout;
  logic       head_ferr, head_perr, empty, full;
  logic [3:0] count;
  logic       drop, ovf;

  int checks = 0;
  int failures = 0;

  rx_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .rx_ferr(rx_ferr), .rx_perr(rx_perr), .rx_ovf(rx_ovf), .rx_clr(rx_clr),
    .rd(rd), .err_clr(err_clr), .dout(dout), .head_ferr(head_ferr),
    .head_perr(head_perr), .empty(empty), .full(full), .count(count),
    .drop(drop), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       rovf;
    logic       rd;
    logic       eclr;
    logic [3:0] cnt;
    logic [7:0] dout;
    logic       hf;
    logic       hp;
    logic       clr;
    logic       drop;
    logic       ovf;
    logic       empty;
  } vec_t;

  vec_t tbl [12];

  // behavioural model state
  logic [9:0] m_q [$];
  bit m_armed, m_ack, m_drop, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rx_rdy = 1'b0; rd = 1'b0; err_clr = 1'b0; rx_ovf = 1'b0;
    rx_ferr = 1'b0; rx_perr = 1'b0; rx_data = 8'h00;
    cyc();
    rst = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic fe, input logic pe);
    rx_rdy = 1'b1; rx_data = d; rx_ferr = fe; rx_perr = pe;
    cyc();
    rx_rdy = 1'b0; rx_ferr = 1'b0; rx_perr = 1'b0;
    cyc();
    cyc();
  endtask

  function automatic logic [17:0] obs();
    return {count, dout, head_ferr, head_perr, rx_clr, drop, ovf, empty};
  endfunction

  function automatic logic [17:0] model_obs();
    logic [3:0] c;
    logic [7:0] d;
    logic hf, hp;
    c = 4'(m_q.size());
    d = 8'h00; hf = 1'b0; hp = 1'b0;
    if (m_q.size() > 0) begin
      d = m_q[0][7:0]; hf = m_q[0][8]; hp = m_q[0][9];
    end
    return {c, d, hf, hp, m_ack, m_drop, m_ovf, (m_q.size() == 0)};
  endfunction

  // one clock edge of the reference model, from the current inputs
  task automatic model_edge();
    bit cap, pp, ok;
    cap = m_armed && rx_rdy;
    pp  = rd && (m_q.size() > 0);
    ok  = cap && (m_q.size() < 8 || pp);
    if (pp) void'(m_q.pop_front());
    if (ok) m_q.push_back({rx_perr, rx_ferr, rx_data});
    if (cap && !ok) m_drop = 1'b1; else if (err_clr) m_drop = 1'b0;
    if (rx_ovf) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
    if (cap) begin
      m_armed = 1'b0; m_ack = 1'b1;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (!m_armed && !rx_rdy) begin
      m_armed = 1'b1;
    end
  endtask

  initial begin
    int pulses;
    int pops;
    logic [7:0] want;

    // reset state, checked while reset is asserted
    #1;
    chk("reset_state", {28'h0, count, empty, full, rx_clr, drop, ovf, dout},
        {28'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // rdy data fe pe rovf rd eclr | cnt dout hf hp clr drop ovf empty
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      rx_rdy = tbl[i].rdy; rx_data = tbl[i].data; rx_ferr = tbl[i].ferr;
      rx_perr = tbl[i].perr; rx_ovf = tbl[i].rovf; rd = tbl[i].rd; err_clr = tbl[i].eclr;
      cyc();
      chk($sformatf("vec%0d", i), {14'h0, obs()},
          {14'h0, tbl[i].cnt, tbl[i].dout, tbl[i].hf, tbl[i].hp, tbl[i].clr,
           tbl[i].drop, tbl[i].ovf, tbl[i].empty});
    end
    rx_rdy = 1'b0; rx_ovf = 1'b0; rd = 1'b0; err_clr = 1'b0;

    // fill past depth, drain in order, then write after wrap
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 10; i++) write_byte(8'(i), 1'b0, 1'b0);
    chk("fill_state", {27'h0, count, full, drop, dout}, {27'h0, 4'd8, 1'b1, 1'b1, 8'h00});
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), {24'h0, dout}, {24'h0, 8'(i)});
      rd = 1'b1;
      cyc();
      rd = 1'b0;
    end
    chk("drained", {27'h0, count, empty, dout}, {27'h0, 4'd0, 1'b1, 8'h00});
    write_byte(8'h55, 1'b0, 1'b0);
    chk("wrap_write", {20'h0, count, dout}, {20'h0, 4'd1, 8'h55});

    // full FIFO with pop and capture on the same edge
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    rx_rdy = 1'b1; rx_data = 8'h77; rd = 1'b1;
    cyc();
    rd = 1'b0; rx_rdy = 1'b0;
    chk("full_pop_wr", {18'h0, count, drop, rx_clr, dout}, {18'h0, 4'd8, 1'b0, 1'b1, 8'h11});
    cyc();
    cyc();
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      want = (i == 7) ? 8'h77 : 8'h11 + 8'(i);
      chk($sformatf("full_drain%0d", i), {24'h0, dout}, {24'h0, want});
      rd = 1'b1;
      cyc();
      rd = 1'b0;
      pops++;
    end
    chk("full_drain_end", {27'h0, count, drop, 8'(pops)}, {27'h0, 4'd0, 1'b0, 8'd8});

    // rx_rdy stuck high gives one entry and one clear pulse; pop on empty ignored
    do_reset();
    @(negedge clk);
    pulses = 0;
    rx_rdy = 1'b1; rx_data = 8'h42;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (rx_clr) pulses++;
    end
    rx_rdy = 1'b0;
    cyc();
    cyc();
    chk("stuck_rdy", {24'h0, count, 4'(pulses)}, {24'h0, 4'd1, 4'd1});
    rd = 1'b1;
    cyc();
    cyc();
    rd = 1'b0;
    chk("rd_empty", {27'h0, count, empty}, {27'h0, 4'd0, 1'b1});

    // asynchronous reset while in WAIT with three entries, then recapture of held byte
    do_reset();
    @(negedge clk);
    write_byte(8'h01, 1'b0, 1'b0);
    write_byte(8'h02, 1'b0, 1'b0);
    rx_rdy = 1'b1; rx_data = 8'h03;
    cyc();
    cyc();
    chk("pre_reset_wait", {27'h0, count, rx_clr}, {27'h0, 4'd3, 1'b0});
    #2 rst = 1'b0;
    #1;
    chk("async_reset", {20'h0, count, empty, full, rx_clr, dout, 1'b0},
        {20'h0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("recapture", {19'h0, count, rx_clr, dout}, {19'h0, 4'd1, 1'b1, 8'h03});
    rx_rdy = 1'b0;
    cyc();

    // randomized traffic against the behavioural model
    do_reset();
    @(negedge clk);
    m_q.delete(); m_armed = 1'b1; m_ack = 1'b0; m_drop = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      chk($sformatf("rand%0d", i), {14'h0, obs()}, {14'h0, model_obs()});
      if (rx_rdy) begin
        if (rx_clr ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0)) rx_rdy = 1'b0;
      end else begin
        rx_rdy = ($urandom_range(0, 2) == 0);
      end
      if (!rx_rdy || $urandom_range(0, 4) == 0) begin
        rx_data = 8'($urandom);
        rx_ferr = ($urandom_range(0, 3) == 0);
        rx_perr = ($urandom_range(0, 3) == 0);
      end
      rx_ovf  = ($urandom_range(0, 7) == 0);
      rd      = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 20 : 65));
      err_clr = ($urandom_range(0, 15) == 0);
      model_edge();
      cyc();
    end
    rx_rdy = 1'b0; rd = 1'b0; rx_ovf = 1'b0; err_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
